// File: rtl/cart_flash_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : cart_flash_responder_if
//  Description : Bundles the Game Boy cartridge bus and the parallel-flash
//                pins seen by cart_flash_responder.
//                CPU side : gb_a, gb_dout, gb_wr, gb_rd  -> responder
//                           gb_din, gb_rdy               <- responder
//                Flash    : flash_d                      -> responder
//                           flash_a, flash_ce_b,
//                           flash_oe_b, flash_adv_b      <- responder
//                Status   : ram_en                       <- responder
//                slave  modport = responder view
//                master modport = CPU + flash environment view
//  Revision    : 1.0  initial release
// ============================================================================
interface cart_flash_responder_if;
   logic [15:0] gb_a;
   logic [7:0]  gb_dout;
   logic        gb_wr;
   logic        gb_rd;
   logic [7:0]  gb_din;
   logic        gb_rdy;
   logic [22:0] flash_a;
   logic [15:0] flash_d;
   logic        flash_ce_b;
   logic        flash_oe_b;
   logic        flash_adv_b;
   logic        ram_en;

   modport slave (
      input  gb_a, gb_dout, gb_wr, gb_rd, flash_d,
      output gb_din, gb_rdy, flash_a, flash_ce_b, flash_oe_b, flash_adv_b, ram_en
   );

   modport master (
      output gb_a, gb_dout, gb_wr, gb_rd, flash_d,
      input  gb_din, gb_rdy, flash_a, flash_ce_b, flash_oe_b, flash_adv_b, ram_en
   );
endinterface
`default_nettype wire

// File: rtl/cart_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module      : cart_flash_responder
//  Description : Cartridge-side responder for the Game Boy external bus.
//                Serves CPU ROM reads from a 16-bit parallel flash using a
//                timed SETUP/WAIT/LATCH sequence and implements the MBC1
//                bank registers (ROM bank low/high, banking mode, RAM enable).
//  Ports       : clk  - bus/flash clock
//                rst  - synchronous active-high reset
//                bus  - cart_flash_responder_if.slave (CPU bus + flash pins)
//  Parameters  : BASE_OFFSET - byte offset of the ROM image inside flash
//                ACC_CYCLES  - flash output settle cycles after OE low (1..15)
//  Revision    : 1.0  initial release
// ============================================================================
module cart_flash_responder #(
   parameter logic [22:0] BASE_OFFSET = 23'h000104,
   parameter int unsigned ACC_CYCLES  = 4
) (
   input  wire logic                   clk,
   input  wire logic                   rst,
   cart_flash_responder_if.slave       bus
);

   localparam logic [3:0] c_wait_init = 4'(ACC_CYCLES - 1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_SETUP = 3'd1,
      ST_WAIT  = 3'd2,
      ST_LATCH = 3'd3,
      ST_HOLD  = 3'd4
   } state_t;

   state_t      r_state;
   logic [3:0]  r_cnt;
   logic [22:0] r_req_byte;
   logic        r_wr_d;
   logic [4:0]  r_rom_bank_lo;
   logic [1:0]  r_bank_hi;
   logic        r_mode;
   logic        r_ram_en;
   logic [7:0]  r_gb_din;
   logic        r_gb_rdy;
   logic [22:0] r_flash_a;
   logic        r_ce_b;
   logic        r_oe_b;
   logic        r_adv_b;

   logic        w_rom;
   logic        w_rd_req;
   logic        w_wr_rise;
   logic [6:0]  w_bank;
   logic [22:0] w_byte_addr;
   logic [7:0]  w_sel_byte;
   logic        w_unused;

   assign w_rom     = ~bus.gb_a[15];
   // A simultaneous write wins: the read is neither started nor continued.
   assign w_rd_req  = bus.gb_rd & ~bus.gb_wr;
   assign w_wr_rise = bus.gb_wr & ~r_wr_d;

   // Lower 16 KiB follows bank 0 unless banking mode 1 routes bank_hi there.
   always_comb begin
      w_bank = 7'd0;
      if (bus.gb_a[14]) begin
         w_bank = {r_bank_hi, r_rom_bank_lo};
      end else if (r_mode) begin
         w_bank = {r_bank_hi, 5'd0};
      end
   end

   assign w_byte_addr = {2'b00, w_bank, bus.gb_a[13:0]} + BASE_OFFSET;
   // Byte lane follows the address latched at access start, not the live bus.
   assign w_sel_byte  = r_req_byte[0] ? bus.flash_d[15:8] : bus.flash_d[7:0];
   assign w_unused    = &{1'b0, bus.gb_dout[7:5]};

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state       <= ST_IDLE;
         r_cnt         <= 4'd0;
         r_req_byte    <= 23'd0;
         r_wr_d        <= 1'b0;
         r_rom_bank_lo <= 5'd1;
         r_bank_hi     <= 2'd0;
         r_mode        <= 1'b0;
         r_ram_en      <= 1'b0;
         r_gb_din      <= 8'hFF;
         r_gb_rdy      <= 1'b0;
         r_flash_a     <= 23'd0;
         r_ce_b        <= 1'b1;
         r_oe_b        <= 1'b1;
         r_adv_b       <= 1'b1;
      end else begin
         r_wr_d <= bus.gb_wr;

         // MBC1 registers update once per write pulse, on its leading edge.
         if (w_wr_rise && !bus.gb_a[15]) begin
            case (bus.gb_a[14:13])
               2'b00: r_ram_en <= (bus.gb_dout[3:0] == 4'hA);
               2'b01: r_rom_bank_lo <= (bus.gb_dout[4:0] == 5'd0) ? 5'd1 : bus.gb_dout[4:0];
               2'b10: r_bank_hi <= bus.gb_dout[1:0];
               default: r_mode <= bus.gb_dout[0];
            endcase
         end

         case (r_state)
            ST_IDLE: begin
               r_gb_rdy <= 1'b0;
               r_ce_b   <= 1'b1;
               r_oe_b   <= 1'b1;
               r_adv_b  <= 1'b1;
               if (w_rd_req) begin
                  if (w_rom) begin
                     r_req_byte <= w_byte_addr;
                     r_flash_a  <= {1'b0, w_byte_addr[22:1]};
                     r_ce_b     <= 1'b0;
                     r_adv_b    <= 1'b0;
                     r_state    <= ST_SETUP;
                  end else begin
                     // Unmapped region: answer with open-bus value, no flash cycle.
                     r_gb_din <= 8'hFF;
                     r_gb_rdy <= 1'b1;
                  end
               end
            end

            ST_SETUP: begin
               if (!w_rd_req) begin
                  r_ce_b  <= 1'b1;
                  r_oe_b  <= 1'b1;
                  r_adv_b <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_adv_b <= 1'b1;
                  r_oe_b  <= 1'b0;
                  r_cnt   <= c_wait_init;
                  r_state <= ST_WAIT;
               end
            end

            ST_WAIT: begin
               if (!w_rd_req) begin
                  r_ce_b  <= 1'b1;
                  r_oe_b  <= 1'b1;
                  r_state <= ST_IDLE;
               end else if (r_cnt == 4'd0) begin
                  r_state <= ST_LATCH;
               end else begin
                  r_cnt <= r_cnt - 4'd1;
               end
            end

            ST_LATCH: begin
               if (!w_rd_req) begin
                  r_ce_b  <= 1'b1;
                  r_oe_b  <= 1'b1;
                  r_state <= ST_IDLE;
               end else begin
                  r_gb_din <= w_sel_byte;
                  r_gb_rdy <= 1'b1;
                  r_state  <= ST_HOLD;
               end
            end

            ST_HOLD: begin
               if (!w_rd_req || !w_rom) begin
                  // Leaving ROM while held is re-evaluated from IDLE next cycle.
                  r_gb_rdy <= 1'b0;
                  r_ce_b   <= 1'b1;
                  r_oe_b   <= 1'b1;
                  r_state  <= ST_IDLE;
               end else if (w_byte_addr != r_req_byte) begin
                  // Address or effective bank moved under a held read: refetch.
                  r_gb_rdy   <= 1'b0;
                  r_req_byte <= w_byte_addr;
                  r_flash_a  <= {1'b0, w_byte_addr[22:1]};
                  r_oe_b     <= 1'b1;
                  r_adv_b    <= 1'b0;
                  r_state    <= ST_SETUP;
               end
            end

            default: begin
               r_gb_rdy <= 1'b0;
               r_ce_b   <= 1'b1;
               r_oe_b   <= 1'b1;
               r_adv_b  <= 1'b1;
               r_state  <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus.gb_din      = r_gb_din;
   assign bus.gb_rdy      = r_gb_rdy;
   assign bus.flash_a     = r_flash_a;
   assign bus.flash_ce_b  = r_ce_b;
   assign bus.flash_oe_b  = r_oe_b;
   assign bus.flash_adv_b = r_adv_b;
   assign bus.ram_en      = r_ram_en;

endmodule
`default_nettype wire

// File: tb/tb_cart_flash_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_cart_flash_responder
//  Description : Directed bench for cart_flash_responder. A vector table of
//                MBC1 writes and ROM/non-ROM reads with hand-computed flash
//                addresses, data bytes and latencies, followed by sequences
//                for read abort, held-read address change and reset in HOLD.
//                Flash contents: word 0x82 = 16'hC300, every other word is
//                {a[7:0]^8'hA5, a[15:8]^{1'b0,a[22:16]}}.
//  Revision    : 1.0  initial release
// ============================================================================
module tb_cart_flash_responder;

   logic clk = 1'b0;
   logic rst = 1'b1;

   cart_flash_responder_if bus ();

   cart_flash_responder #(
      .BASE_OFFSET (23'h000104),
      .ACC_CYCLES  (4)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   always #5 clk = ~clk;

   function automatic logic [15:0] flash_word(input logic [22:0] a);
      if (a == 23'h000082) return 16'hC300;
      return {a[7:0] ^ 8'hA5, a[15:8] ^ {1'b0, a[22:16]}};
   endfunction

   assign bus.flash_d = flash_word(bus.flash_a);

   int n_checks = 0;
   int n_errors = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   typedef struct {
      bit          is_rd;
      logic [15:0] a;
      logic [7:0]  d;
      logic [22:0] exp_fa;
      logic [7:0]  exp_din;
      int          exp_lat;
      bit          exp_ram;
   } vec_t;

   localparam int c_nvec = 19;
   vec_t vecs [c_nvec];

   task automatic do_write(input logic [15:0] a, input logic [7:0] d);
      @(negedge clk);
      bus.gb_a    = a;
      bus.gb_dout = d;
      bus.gb_wr   = 1'b1;
      @(negedge clk);
      bus.gb_wr   = 1'b0;
      @(negedge clk);
   endtask

   // Raises gb_rd and waits (bounded) for gb_rdy; gb_rd is left high.
   task automatic do_read(input logic [15:0] a, output int lat, output int advs, output bit ce_seen);
      @(negedge clk);
      bus.gb_a  = a;
      bus.gb_rd = 1'b1;
      lat       = 0;
      advs      = 0;
      ce_seen   = 1'b0;
      do begin
         @(negedge clk);
         lat++;
         if (!bus.flash_adv_b) advs++;
         if (!bus.flash_ce_b) ce_seen = 1'b1;
      end while (!bus.gb_rdy && lat < 40);
   endtask

   task automatic end_read(input string tag);
      @(negedge clk);
      bus.gb_rd = 1'b0;
      @(negedge clk);
      check({tag, " rdy_after_rd_low"}, 32'(bus.gb_rdy), 32'd0);
      check({tag, " ce_after_rd_low"},  32'(bus.flash_ce_b), 32'd1);
      check({tag, " oe_after_rd_low"},  32'(bus.flash_oe_b), 32'd1);
   endtask

   task automatic check_reset_outputs(input string tag);
      check({tag, " gb_din"},      32'(bus.gb_din),      32'hFF);
      check({tag, " gb_rdy"},      32'(bus.gb_rdy),      32'd0);
      check({tag, " flash_a"},     32'(bus.flash_a),     32'd0);
      check({tag, " flash_ce_b"},  32'(bus.flash_ce_b),  32'd1);
      check({tag, " flash_oe_b"},  32'(bus.flash_oe_b),  32'd1);
      check({tag, " flash_adv_b"}, 32'(bus.flash_adv_b), 32'd1);
      check({tag, " ram_en"},      32'(bus.ram_en),      32'd0);
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog: simulation time limit reached, got timeout, expected $finish");
      $fatal(1);
   end

   initial begin
      int lat;
      int advs;
      bit ce_seen;
      string tag;

      //           rd  addr      data   flash_a       din    lat ram
      vecs[0]  = '{1, 16'h0000, 8'h00, 23'h000082, 8'h00, 7, 0};
      vecs[1]  = '{0, 16'h2000, 8'h00, 23'h0,      8'h00, 0, 0};
      vecs[2]  = '{1, 16'h4001, 8'h00, 23'h002082, 8'h27, 7, 0};
      vecs[3]  = '{0, 16'h2000, 8'h05, 23'h0,      8'h00, 0, 0};
      vecs[4]  = '{1, 16'h5555, 8'h00, 23'h00AB2C, 8'h89, 7, 0};
      vecs[5]  = '{0, 16'h2000, 8'h1F, 23'h0,      8'h00, 0, 0};
      vecs[6]  = '{0, 16'h4000, 8'h03, 23'h0,      8'h00, 0, 0};
      vecs[7]  = '{1, 16'h7FFF, 8'h00, 23'h100081, 8'h24, 7, 0};
      vecs[8]  = '{0, 16'h6000, 8'h01, 23'h0,      8'h00, 0, 0};
      vecs[9]  = '{1, 16'h0000, 8'h00, 23'h0C0082, 8'h0C, 7, 0};
      vecs[10] = '{1, 16'h1234, 8'h00, 23'h0C099C, 8'h05, 7, 0};
      vecs[11] = '{0, 16'h6000, 8'h00, 23'h0,      8'h00, 0, 0};
      vecs[12] = '{1, 16'h1234, 8'h00, 23'h00099C, 8'h09, 7, 0};
      vecs[13] = '{0, 16'h0000, 8'h0A, 23'h0,      8'h00, 0, 1};
      vecs[14] = '{0, 16'h0000, 8'h0B, 23'h0,      8'h00, 0, 0};
      vecs[15] = '{1, 16'hA000, 8'h00, 23'h0,      8'hFF, 1, 0};
      vecs[16] = '{0, 16'h4000, 8'h00, 23'h0,      8'h00, 0, 0};
      vecs[17] = '{0, 16'h2000, 8'h00, 23'h0,      8'h00, 0, 0};
      vecs[18] = '{1, 16'h4001, 8'h00, 23'h002082, 8'h27, 7, 0};

      bus.gb_a    = 16'h0000;
      bus.gb_dout = 8'h00;
      bus.gb_wr   = 1'b0;
      bus.gb_rd   = 1'b0;

      repeat (3) @(negedge clk);
      check_reset_outputs("reset");
      rst = 1'b0;

      for (int i = 0; i < c_nvec; i++) begin
         tag = $sformatf("vec%0d", i);
         if (vecs[i].is_rd) begin
            do_read(vecs[i].a, lat, advs, ce_seen);
            check({tag, " latency"}, 32'(lat), 32'(vecs[i].exp_lat));
            check({tag, " gb_din"},  32'(bus.gb_din), 32'(vecs[i].exp_din));
            if (vecs[i].exp_lat > 1) begin
               check({tag, " flash_a"},   32'(bus.flash_a), 32'(vecs[i].exp_fa));
               check({tag, " adv_cycles"}, 32'(advs), 32'd1);
               check({tag, " oe_in_hold"}, 32'(bus.flash_oe_b), 32'd0);
            end else begin
               check({tag, " ce_touched"}, 32'(ce_seen), 32'd0);
            end
            end_read(tag);
         end else begin
            do_write(vecs[i].a, vecs[i].d);
            check({tag, " ram_en"}, 32'(bus.ram_en), 32'(vecs[i].exp_ram));
         end
      end

      // Drop gb_rd while the flash is in its settle window.
      @(negedge clk);
      bus.gb_a  = 16'h0000;
      bus.gb_rd = 1'b1;
      repeat (3) @(negedge clk);
      check("abort oe_low_in_wait", 32'(bus.flash_oe_b), 32'd0);
      bus.gb_rd = 1'b0;
      @(negedge clk);
      check("abort ce_b", 32'(bus.flash_ce_b), 32'd1);
      check("abort oe_b", 32'(bus.flash_oe_b), 32'd1);
      check("abort rdy",  32'(bus.gb_rdy),     32'd0);
      check("abort din_kept", 32'(bus.gb_din), 32'h27);

      // Fresh read after the abort, then move the address while held.
      do_read(16'h0000, lat, advs, ce_seen);
      check("post_abort latency", 32'(lat), 32'd7);
      check("post_abort din", 32'(bus.gb_din), 32'h00);
      @(negedge clk);
      bus.gb_a = 16'h4001;
      @(negedge clk);
      check("hold_move rdy_drop", 32'(bus.gb_rdy), 32'd0);
      lat = 1;
      while (!bus.gb_rdy && lat < 40) begin
         @(negedge clk);
         lat++;
      end
      check("hold_move latency", 32'(lat), 32'd7);
      check("hold_move flash_a", 32'(bus.flash_a), 32'h002082);
      check("hold_move din", 32'(bus.gb_din), 32'h27);
      end_read("hold_move");

      // Reset while holding a banked read restores outputs and bank registers.
      do_write(16'h0000, 8'h0A);
      do_write(16'h2000, 8'h05);
      do_write(16'h4000, 8'h02);
      do_write(16'h6000, 8'h01);
      do_read(16'h5555, lat, advs, ce_seen);
      check("pre_rst flash_a", 32'(bus.flash_a), 32'h08AB2C);
      check("pre_rst din", 32'(bus.gb_din), 32'h89);
      check("pre_rst ram_en", 32'(bus.ram_en), 32'd1);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      check_reset_outputs("rst_in_hold");
      rst = 1'b0;
      bus.gb_rd = 1'b0;
      do_read(16'h5555, lat, advs, ce_seen);
      check("post_rst bank flash_a", 32'(bus.flash_a), 32'h002B2C);
      check("post_rst bank din", 32'(bus.gb_din), 32'h89);
      end_read("post_rst_bank");
      do_write(16'h4000, 8'h01);
      do_read(16'h0000, lat, advs, ce_seen);
      check("post_rst mode flash_a", 32'(bus.flash_a), 32'h000082);
      check("post_rst mode din", 32'(bus.gb_din), 32'h00);
      end_read("post_rst_mode");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
`default_nettype wire
